// File: rtl/cpu_sequencer_pkg.sv
// Shared CPU encodings: opcodes, sequencer states, PC source, write-back select and ALU ops.
// Used by the sequencer, its opcode decoder and the datapath.
package cpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_INC  = 4'b0101;
    localparam logic [3:0] OP_NEG  = 4'b0110;
    localparam logic [3:0] OP_SUB  = 4'b0111;
    localparam logic [3:0] OP_J    = 4'b1000;
    localparam logic [3:0] OP_BRZ  = 4'b1001;
    localparam logic [3:0] OP_JM   = 4'b1010;
    localparam logic [3:0] OP_BRN  = 4'b1011;
    localparam logic [3:0] OP_LD   = 4'b1110;
    localparam logic [3:0] OP_SVPC = 4'b1111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [1:0] PC_SRC_INC = 2'd0;
    localparam logic [1:0] PC_SRC_RS  = 2'd1;
    localparam logic [1:0] PC_SRC_MEM = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;

    localparam logic [2:0] ALU_NONE = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_INC  = 3'd2;
    localparam logic [2:0] ALU_NEG  = 3'd3;
    localparam logic [2:0] ALU_SUB  = 3'd4;
    localparam logic [2:0] ALU_PCRS = 3'd5;

    // Instruction classes: each class shares one path through the state machine.
    typedef enum logic [2:0] {
        CLS_NOP  = 3'd0,
        CLS_JUMP = 3'd1,
        CLS_BRZ  = 3'd2,
        CLS_BRN  = 3'd3,
        CLS_ALU  = 3'd4,
        CLS_LD   = 3'd5,
        CLS_ST   = 3'd6,
        CLS_JM   = 3'd7
    } op_class_t;

endpackage

// File: rtl/cpu_sequencer_op_decode.sv
// Combinational decode of the latched opcode into an instruction class and ALU operation.
// Undefined opcodes decode as NOP with o_illegal set.
module op_decode
    import cpu_pkg::*;
(
    input  logic [3:0] i_opcode,
    output op_class_t  o_cls,
    output logic [2:0] o_alu_op,
    output logic       o_illegal
);

    always_comb begin
        o_cls     = CLS_NOP;
        o_alu_op  = ALU_NONE;
        o_illegal = 1'b0;
        case (i_opcode)
            OP_NOP:  o_cls = CLS_NOP;
            OP_ST:   o_cls = CLS_ST;
            OP_ADD:  begin o_cls = CLS_ALU; o_alu_op = ALU_ADD;  end
            OP_INC:  begin o_cls = CLS_ALU; o_alu_op = ALU_INC;  end
            OP_NEG:  begin o_cls = CLS_ALU; o_alu_op = ALU_NEG;  end
            OP_SUB:  begin o_cls = CLS_ALU; o_alu_op = ALU_SUB;  end
            OP_SVPC: begin o_cls = CLS_ALU; o_alu_op = ALU_PCRS; end
            OP_J:    o_cls = CLS_JUMP;
            OP_BRZ:  o_cls = CLS_BRZ;
            OP_JM:   o_cls = CLS_JM;
            OP_BRN:  o_cls = CLS_BRN;
            OP_LD:   o_cls = CLS_LD;
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle CPU control sequencer: FETCH/DECODE/EXEC/MEM/WB with a MEM_LAT read wait counter.
// Define SEQ_PERF_CNT_EN to build the retired-instruction counter; otherwise instr_retired is tied to 0.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  opcode,
    input  logic        zero_flag,
    input  logic        neg_flag,
    output logic [2:0]  state,
    output logic        pc_wr,
    output logic [1:0]  pc_src,
    output logic        reg_wrt,
    output logic        mem_read,
    output logic        mem_wrt,
    output logic [2:0]  alu_op,
    output logic [1:0]  wb_sel,
    output logic        illegal,
    output logic [31:0] instr_retired
);

    localparam logic [3:0] LAST_WAIT = 4'(MEM_LAT - 1);

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_opcode;
    logic [3:0] r_wait;
    op_class_t  w_cls;
    logic [2:0] w_alu_op;
    logic       w_illegal;
    logic       w_mem_last;

    op_decode u_op_decode (
        .i_opcode (r_opcode),
        .o_cls    (w_cls),
        .o_alu_op (w_alu_op),
        .o_illegal(w_illegal)
    );

    assign w_mem_last = (r_wait >= LAST_WAIT);
    assign state      = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_FETCH;
            r_opcode <= OP_NOP;
            r_wait   <= 4'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_opcode <= opcode;
            end
            // Held at 0 outside MEM so every MEM visit starts counting from 0.
            if (r_state != S_MEM) begin
                r_wait <= 4'd0;
            end else if (!w_mem_last) begin
                r_wait <= r_wait + 4'd1;
            end
        end
    end

    always_comb begin
        w_next   = r_state;
        pc_wr    = 1'b0;
        pc_src   = PC_SRC_INC;
        reg_wrt  = 1'b0;
        mem_read = 1'b0;
        mem_wrt  = 1'b0;
        alu_op   = ALU_NONE;
        wb_sel   = WB_ALU;
        illegal  = 1'b0;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: w_next = S_EXEC;
            S_EXEC: begin
                alu_op = w_alu_op;
                w_next = S_FETCH;
                case (w_cls)
                    CLS_NOP: begin
                        pc_wr   = 1'b1;
                        illegal = w_illegal;
                    end
                    CLS_JUMP: begin
                        pc_wr  = 1'b1;
                        pc_src = PC_SRC_RS;
                    end
                    CLS_BRZ: begin
                        pc_wr  = 1'b1;
                        pc_src = zero_flag ? PC_SRC_RS : PC_SRC_INC;
                    end
                    CLS_BRN: begin
                        pc_wr  = 1'b1;
                        pc_src = neg_flag ? PC_SRC_RS : PC_SRC_INC;
                    end
                    CLS_ALU: w_next = S_WB;
                    default: w_next = S_MEM;
                endcase
            end
            S_MEM: begin
                case (w_cls)
                    CLS_ST: begin
                        mem_wrt = 1'b1;
                        pc_wr   = 1'b1;
                        w_next  = S_FETCH;
                    end
                    CLS_LD: begin
                        mem_read = 1'b1;
                        if (w_mem_last) begin
                            w_next = S_WB;
                        end
                    end
                    CLS_JM: begin
                        mem_read = 1'b1;
                        if (w_mem_last) begin
                            pc_wr  = 1'b1;
                            pc_src = PC_SRC_MEM;
                            w_next = S_FETCH;
                        end
                    end
                    default: w_next = S_FETCH;
                endcase
            end
            S_WB: begin
                reg_wrt = 1'b1;
                pc_wr   = 1'b1;
                alu_op  = w_alu_op;
                wb_sel  = (w_cls == CLS_LD) ? WB_MEM : WB_ALU;
                w_next  = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] r_retired;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retired <= 32'd0;
        end else if (pc_wr) begin
            r_retired <= r_retired + 32'd1;
        end
    end

    assign instr_retired = r_retired;
`else
    assign instr_retired = 32'd0;
`endif

endmodule
